avg_frame_sequencer: RTL and testbench
======================================

// Module: avg_frame_sequencer
// PURPOSE
//  Control sequencer for the per-bin growing-sum averager. Tracks bin index and frame count
//  within an averaging window. Issues load/accumulate strobes per FFT sample, then drains the
//  BINS averaged results over a valid/ready stream. Sits between the FFT output and the
//  averager datapath (accumulator RAM + shifter); owns no data, only control.
// PARAMETERS
//  BINS        4   FFT bins per frame (>=2)
//  N_AVGS_MAX  7   max log2(frames averaged); window = 2**cfg_log2_avgs frames
//  BIN_W       $clog2(BINS)  bin index width (derived, do not override)
//  LOG_W       $clog2(N_AVGS_MAX+1)  cfg/shift width (derived)
// PORTS
//  clk            in   1      single clock, all logic on posedge
//  reset          in   1      synchronous, active-high
//  cfg_log2_avgs  in   LOG_W  averages per window (log2); sampled only at window start
//  clr_flags      in   1      clears sticky overflow/frame_err
//  fft_valid      in   1      one FFT sample present this cycle
//  fft_last       in   1      qualifies fft_valid: last bin of frame
//  acc_en         out  1      datapath: write accumulator[acc_bin] (registered, 1-cycle latency)
//  acc_load       out  1      with acc_en: overwrite (first frame) instead of add
//  acc_bin        out  BIN_W  accumulator address for acc_en
//  shift          out  LOG_W  latched log2 for datapath divide-by-shift, stable for whole window+drain
//  out_valid      out  1      drain stream valid; datapath presents mean[out_bin]
//  out_ready      in   1      drain stream ready
//  out_bin        out  BIN_W  bin being drained
//  out_last       out  1      out_valid && out_bin==BINS-1
//  busy           out  1      state != IDLE
//  frame_cnt      out  N_AVGS_MAX  frames completed in current window
//  overflow       out  1      sticky: sample arrived during DRAIN (dropped)
//  frame_err      out  1      sticky: fft_last at wrong bin, or bin BINS-1 without fft_last
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; shift=0; internal bin_idx=0.
//  FSM IDLE -> ACCUM -> DRAIN -> IDLE.
//   IDLE: on fft_valid latch shift<=cfg_log2_avgs, treat sample as bin 0 of frame 0, -> ACCUM.
//   ACCUM: each fft_valid advances bin_idx (wraps BINS-1 -> 0 on frame end). On frame end,
//     frame_cnt++. If frame_cnt==2**shift-1 at frame end: frame_cnt<=0, -> DRAIN.
//   DRAIN: out_valid=1, out_bin counts 0..BINS-1, advances on out_valid&&out_ready;
//     handshake on out_last -> IDLE. out_bin/out_valid hold while !out_ready.
//  Strobes: acc_en/acc_bin/acc_load registered from fft_valid; asserted the cycle after the
//   sample; datapath delays data by 1 to align. acc_load=1 for every sample of frame 0.
//  shift=0 window: single frame; every sample loads; DRAIN follows each frame.
//  fft_valid in DRAIN: no acc_en, overflow<=1, sample dropped; a frame starting in DRAIN is
//   ignored until frame end (first fft_last); the next frame in IDLE starts a new window.
//  Framing: fft_last with bin_idx!=BINS-1, or bin_idx==BINS-1 without fft_last -> frame_err<=1,
//   bin_idx<=0, frame_cnt<=0, window restarts (next frame loads); no DRAIN for the bad window.
//  clr_flags and a flag-set event in the same cycle: set wins.
//  cfg_log2_avgs changes mid-window: ignored until next IDLE->ACCUM; values >N_AVGS_MAX clamp.
//  reset mid-window or mid-drain: immediate return to IDLE, partial sums abandoned.
// STRUCTURE
//  Package avg_pkg: typedef enum logic [1:0] {S_IDLE,S_ACCUM,S_DRAIN} avg_state_t;
//   shared BINS/N_AVGS_MAX defaults reused by the averager wrapper.
//  One sub-module: avg_bin_counter (BIN_W wrap counter with en, clr, at_last) instantiated
//   twice (acc bin index, drain index). FSM, frame counter and flags live in the top.
// TESTING
//  1 BINS=4, cfg=2, 4 frames back-to-back, out_ready=1 -> acc_load only frame 0; acc_bin
//    0,1,2,3 repeating one cycle after input; DRAIN out_bin 0..3, out_last on 3; busy drops.
//  2 cfg=0, 1 frame -> 4 acc_en all with acc_load=1, then 4-beat drain, frame_cnt stays 0.
//  3 DRAIN with out_ready toggling 1,0,0,1,... -> out_bin holds while stalled, exactly 4 beats.
//  4 fft_last on bin 2 in frame 1 -> frame_err=1, no DRAIN, next frame has acc_load=1;
//    clr_flags -> frame_err=0.
//  5 new frame during stalled DRAIN (out_ready=0) -> overflow=1, no acc_en, drain completes.
//  6 reset asserted mid-ACCUM frame 2 -> next cycle all outputs 0; a new frame restarts
//    with acc_load=1; cfg change mid-window leaves shift unchanged until next window.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared types and defaults for the per-bin growing-sum averager.
// Used by the control sequencer and the averager wrapper.
package avg_pkg;

    localparam int BINS_DEF       = 4;
    localparam int N_AVGS_MAX_DEF = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN
    } avg_state_t;

endpackage

// File: rtl/avg_bin_counter.sv
// Modulo-N bin index counter with enable, synchronous clear and
// a last-bin flag; clear takes priority over enable.
module avg_bin_counter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_last
);

    assign at_last = (count == W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/avg_frame_sequencer.sv
// Control sequencer for the growing-sum averager: accumulate strobes
// per FFT sample over a 2**shift frame window, then drain BINS means.
module avg_frame_sequencer
    import avg_pkg::*;
#(
    parameter int  BINS       = BINS_DEF,
    parameter int  N_AVGS_MAX = N_AVGS_MAX_DEF,
    localparam int BIN_W      = $clog2(BINS),
    localparam int LOG_W      = $clog2(N_AVGS_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LOG_W-1:0]      cfg_log2_avgs,
    input  logic                  clr_flags,
    input  logic                  fft_valid,
    input  logic                  fft_last,
    output logic                  acc_en,
    output logic                  acc_load,
    output logic [BIN_W-1:0]      acc_bin,
    output logic [LOG_W-1:0]      shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_last,
    output logic                  busy,
    output logic [N_AVGS_MAX-1:0] frame_cnt,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int               FW      = N_AVGS_MAX + 1;
    localparam logic [LOG_W-1:0] LOG_MAX = LOG_W'(N_AVGS_MAX);

    avg_state_t state, state_n;

    logic [BIN_W-1:0]      bin_idx;
    logic [BIN_W-1:0]      drain_idx;
    logic                  bin_last;
    logic                  drain_last;
    logic                  bin_adv;
    logic                  bin_clr;
    logic                  drain_adv;
    logic                  acc_take;
    logic                  frame_end;
    logic                  frame_clr;
    logic                  win_end;
    logic                  ferr_set;
    logic                  ovf_set;
    logic                  latch_cfg;
    logic                  skip;
    logic                  skip_n;
    logic [LOG_W-1:0]      cfg_clamped;
    logic [FW-1:0]         win_len;
    logic [N_AVGS_MAX-1:0] win_last;

    assign cfg_clamped = (cfg_log2_avgs > LOG_MAX) ? LOG_MAX : cfg_log2_avgs;
    assign win_len     = FW'(1) << shift;
    assign win_last    = N_AVGS_MAX'(win_len - FW'(1));
    assign win_end     = (frame_cnt == win_last);

    assign out_valid = (state == S_DRAIN);
    assign out_bin   = drain_idx;
    assign out_last  = out_valid && drain_last;
    assign busy      = (state != S_IDLE);

    avg_bin_counter #(.N(BINS), .W(BIN_W)) u_acc_bin (
        .clk     (clk),
        .reset   (reset),
        .en      (bin_adv),
        .clr     (bin_clr),
        .count   (bin_idx),
        .at_last (bin_last)
    );

    avg_bin_counter #(.N(BINS), .W(BIN_W)) u_drain_bin (
        .clk     (clk),
        .reset   (reset),
        .en      (drain_adv),
        .clr     (1'b0),
        .count   (drain_idx),
        .at_last (drain_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        acc_take  = 1'b0;
        bin_adv   = 1'b0;
        bin_clr   = 1'b0;
        drain_adv = 1'b0;
        frame_end = 1'b0;
        frame_clr = 1'b0;
        ferr_set  = 1'b0;
        ovf_set   = 1'b0;
        latch_cfg = 1'b0;
        skip_n    = skip;
        unique case (state)
            S_IDLE: begin
                if (fft_valid) begin
                    // Tail of a frame that began during drain is discarded.
                    if (skip) begin
                        skip_n = !fft_last;
                    end else if (fft_last) begin
                        ferr_set = 1'b1;
                        bin_clr  = 1'b1;
                    end else begin
                        acc_take  = 1'b1;
                        bin_adv   = 1'b1;
                        latch_cfg = 1'b1;
                        state_n   = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (fft_valid) begin
                    if (fft_last != bin_last) begin
                        ferr_set  = 1'b1;
                        bin_clr   = 1'b1;
                        frame_clr = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        acc_take  = 1'b1;
                        bin_adv   = 1'b1;
                        frame_end = bin_last;
                        if (bin_last && win_end) begin
                            state_n = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                drain_adv = out_ready;
                if (fft_valid) begin
                    ovf_set = 1'b1;
                    skip_n  = !fft_last;
                end
                if (out_ready && drain_last) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_en    <= 1'b0;
            acc_load  <= 1'b0;
            acc_bin   <= '0;
            shift     <= '0;
            frame_cnt <= '0;
            skip      <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            acc_en   <= acc_take;
            acc_load <= acc_take && (state == S_IDLE || frame_cnt == '0);
            acc_bin  <= acc_take ? bin_idx : '0;
            skip     <= skip_n;
            if (latch_cfg) begin
                shift <= cfg_clamped;
            end
            if (frame_clr || (frame_end && win_end)) begin
                frame_cnt <= '0;
            end else if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            overflow  <= ovf_set || (overflow && !clr_flags);
            frame_err <= ferr_set || (frame_err && !clr_flags);
        end
    end

endmodule

// File: tb/tb_avg_frame_sequencer.sv
// Scoreboard bench for avg_frame_sequencer: expected strobes and
// drain beats are queued at stimulus time and popped at the outputs.
module tb_avg_frame_sequencer;

    localparam int BINS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] cfg_log2_avgs;
    logic       clr_flags;
    logic       fft_valid;
    logic       fft_last;
    logic       acc_en;
    logic       acc_load;
    logic [1:0] acc_bin;
    logic [2:0] shift;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_bin;
    logic       out_last;
    logic       busy;
    logic [6:0] frame_cnt;
    logic       overflow;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int beats    = 0;
    int b0;
    int aq[$];
    int dq[$];

    always #5 clk = ~clk;

    avg_frame_sequencer #(.BINS(4), .N_AVGS_MAX(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_log2_avgs (cfg_log2_avgs),
        .clr_flags     (clr_flags),
        .fft_valid     (fft_valid),
        .fft_last      (fft_last),
        .acc_en        (acc_en),
        .acc_load      (acc_load),
        .acc_bin       (acc_bin),
        .shift         (shift),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bin       (out_bin),
        .out_last      (out_last),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .overflow      (overflow),
        .frame_err     (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    logic       prev_stall = 1'b0;
    logic [1:0] prev_bin   = 2'd0;

    always @(negedge clk) begin
        int e;
        if (acc_en) begin
            if (aq.size() == 0) begin
                check("acc_unexpected", 1, 0);
            end else begin
                e = aq.pop_front();
                check("acc_bin", acc_bin, e >> 1);
                check("acc_load", acc_load, e & 1);
            end
        end
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_bin", out_bin, prev_bin);
        end
        if (out_valid) check("out_last", out_last, out_bin == 2'd3);
        if (out_valid && out_ready) begin
            beats++;
            if (dq.size() == 0) begin
                check("drain_unexpected", 1, 0);
            end else begin
                e = dq.pop_front();
                check("out_bin", out_bin, e);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_bin   = out_bin;
    end

    task automatic send(input int b, input bit last, input bit push,
                        input bit load);
        fft_valid = 1'b1;
        fft_last  = last;
        if (push) aq.push_back(b * 2 + int'(load));
        @(posedge clk);
        #1;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
    endtask

    task automatic frame(input bit load, input bit drain);
        for (int b = 0; b < BINS; b++) send(b, b == BINS - 1, 1'b1, load);
        if (drain) for (int b = 0; b < BINS; b++) dq.push_back(b);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick(1);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        cfg_log2_avgs = 3'd2;
        clr_flags     = 1'b0;
        fft_valid     = 1'b0;
        fft_last      = 1'b0;
        out_ready     = 1'b1;
        tick(3);
        check("rst_acc_en", acc_en, 0);
        check("rst_acc_load", acc_load, 0);
        check("rst_acc_bin", acc_bin, 0);
        check("rst_shift", shift, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_flags", {overflow, frame_err}, 0);
        reset = 1'b0;
        tick(1);

        // 4-frame window, free-running drain
        b0 = beats;
        frame(1'b1, 1'b0);
        check("t1_shift", shift, 2);
        check("t1_cnt1", frame_cnt, 1);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        check("t1_cnt3", frame_cnt, 3);
        frame(1'b0, 1'b1);
        check("t1_cnt0", frame_cnt, 0);
        check("t1_drain", out_valid, 1);
        wait_idle();
        check("t1_beats", beats - b0, 4);

        // single-frame window
        cfg_log2_avgs = 3'd0;
        b0 = beats;
        frame(1'b1, 1'b1);
        check("t2_shift", shift, 0);
        check("t2_cnt", frame_cnt, 0);
        check("t2_drain", out_valid, 1);
        wait_idle();
        check("t2_beats", beats - b0, 4);

        // stalled drain
        out_ready = 1'b0;
        b0 = beats;
        frame(1'b1, 1'b1);
        for (int i = 0; i < 40 && busy; i++) begin
            out_ready = (i % 3 == 0);
            tick(1);
        end
        check("t3_beats", beats - b0, 4);
        check("t3_idle", busy, 0);
        out_ready = 1'b1;

        // framing errors
        cfg_log2_avgs = 3'd2;
        frame(1'b1, 1'b0);
        send(0, 1'b0, 1'b1, 1'b0);
        send(1, 1'b0, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0, 1'b0);
        check("t4_err", frame_err, 1);
        check("t4_no_drain", busy, 0);
        check("t4_cnt", frame_cnt, 0);
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b1);
        wait_idle();
        pulse_clr();
        check("t4_clr", frame_err, 0);
        clr_flags = 1'b1;
        send(0, 1'b1, 1'b0, 1'b0);
        clr_flags = 1'b0;
        check("t4_set_wins", frame_err, 1);
        pulse_clr();
        cfg_log2_avgs = 3'd0;
        for (int b = 0; b < BINS - 1; b++) send(b, 1'b0, 1'b1, 1'b1);
        send(3, 1'b0, 1'b0, 1'b0);
        check("t4_no_last", frame_err, 1);
        check("t4_no_last_idle", busy, 0);
        pulse_clr();

        // samples during drain
        out_ready = 1'b0;
        frame(1'b1, 1'b1);
        for (int b = 0; b < BINS; b++) send(b, b == BINS - 1, 1'b0, 1'b0);
        check("t5_ovf", overflow, 1);
        check("t5_busy", busy, 1);
        check("t5_hold_bin", out_bin, 0);
        out_ready = 1'b1;
        wait_idle();
        out_ready = 1'b0;
        frame(1'b1, 1'b1);
        send(0, 1'b0, 1'b0, 1'b0);
        send(1, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        wait_idle();
        send(2, 1'b0, 1'b0, 1'b0);
        send(3, 1'b1, 1'b0, 1'b0);
        check("t5_tail_dropped", busy, 0);
        frame(1'b1, 1'b1);
        wait_idle();
        check("t5_ovf_sticky", overflow, 1);
        pulse_clr();
        check("t5_ovf_clr", overflow, 0);

        // reset mid-window, cfg change mid-window
        cfg_log2_avgs = 3'd2;
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        send(0, 1'b0, 1'b1, 1'b0);
        send(1, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        tick(1);
        check("t6_acc_en", acc_en, 0);
        check("t6_busy", busy, 0);
        check("t6_cnt", frame_cnt, 0);
        check("t6_shift", shift, 0);
        reset = 1'b0;
        cfg_log2_avgs = 3'd1;
        frame(1'b1, 1'b0);
        check("t6_shift1", shift, 1);
        cfg_log2_avgs = 3'd3;
        frame(1'b0, 1'b1);
        check("t6_shift_hold", shift, 1);
        wait_idle();
        frame(1'b1, 1'b0);
        check("t6_shift3", shift, 3);
        check("t6_cnt1", frame_cnt, 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;

        check("aq_empty", aq.size(), 0);
        check("dq_empty", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
